// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: cache freeze, load-use bubble, branch flush/redirect.
// Optional event counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_valid,
    input  logic        id_rs2_valid,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_rd_valid,
    input  logic        ex_is_load,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    output logic        cache_stall,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        hazard_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        busy_flush
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_cache_stall_cycles,
    output logic [31:0] perf_load_use_bubbles,
    output logic [31:0] perf_redirects
`endif
);

    typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit               MULTI    = (FLUSH_CYCLES > 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pc_q;
    logic             load_use;

    assign load_use = ex_is_load & ex_rd_valid & (ex_rd_addr != 5'd0) &
                      ((id_rs1_valid & (id_rs1_addr == ex_rd_addr)) |
                       (id_rs2_valid & (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        cache_stall  = icache_stall | dcache_stall;
        busy_flush   = (state != RUN);
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        hazard_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = pc_q;
        if (!cache_stall) begin
            case (state)
                RUN: begin
                    // Branch wins over load-use: the dependent instruction is wrong-path.
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        pc_redirect = 1'b1;
                        redirect_pc = branch_target;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        hazard_stall = 1'b1;
                    end
                end
                PEND: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    pc_redirect = 1'b1;
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            pc_q  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        pc_q <= branch_target;
                        if (cache_stall) begin
                            state <= PEND;
                        end else if (MULTI) begin
                            state <= FLUSH;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                PEND: begin
                    if (!cache_stall) begin
                        if (MULTI) begin
                            state <= FLUSH;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    // A stalled cycle does not count toward the flush length.
                    if (!cache_stall) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt <= CNT_W'(1)) state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cache_stall_cycles <= '0;
            perf_load_use_bubbles   <= '0;
            perf_redirects          <= '0;
        end else begin
            if (cache_stall)  perf_cache_stall_cycles <= perf_cache_stall_cycles + 32'd1;
            if (hazard_stall) perf_load_use_bubbles   <= perf_load_use_bubbles + 32'd1;
            if (pc_redirect)  perf_redirects          <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two instances (FLUSH_CYCLES=1 and 3) share one stimulus stream.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_valid, id_rs2_valid, ex_rd_valid, ex_is_load;
    logic        branch_taken, icache_stall, dcache_stall;
    logic [31:0] branch_target;

    logic        cs1, ps1, is1, hs1, iff1, eff1, pr1, bf1;
    logic        cs3, ps3, is3, hs3, iff3, eff3, pr3, bf3;
    logic [31:0] rpc1, rpc3;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] pcs1, plu1, prd1, pcs3, plu3, prd3;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_valid(id_rs1_valid), .id_rs2_valid(id_rs2_valid), .ex_rd_addr(ex_rd_addr),
        .ex_rd_valid(ex_rd_valid), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .branch_target(branch_target), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .cache_stall(cs1), .pc_stall(ps1), .if_id_stall(is1), .hazard_stall(hs1),
        .if_id_flush(iff1), .id_ex_flush(eff1), .pc_redirect(pr1), .redirect_pc(rpc1),
        .busy_flush(bf1)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_cache_stall_cycles(pcs1), .perf_load_use_bubbles(plu1), .perf_redirects(prd1)
`endif
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_valid(id_rs1_valid), .id_rs2_valid(id_rs2_valid), .ex_rd_addr(ex_rd_addr),
        .ex_rd_valid(ex_rd_valid), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .branch_target(branch_target), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .cache_stall(cs3), .pc_stall(ps3), .if_id_stall(is3), .hazard_stall(hs3),
        .if_id_flush(iff3), .id_ex_flush(eff3), .pc_redirect(pr3), .redirect_pc(rpc3),
        .busy_flush(bf3)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_cache_stall_cycles(pcs3), .perf_load_use_bubbles(plu3), .perf_redirects(prd3)
`endif
    );

    // Output vector: {cache_stall, pc_stall, if_id_stall, hazard_stall, if_id_flush, id_ex_flush, pc_redirect, busy_flush}
    logic [7:0] v1, v3;
    assign v1 = {cs1, ps1, is1, hs1, iff1, eff1, pr1, bf1};
    assign v3 = {cs3, ps3, is3, hs3, iff3, eff3, pr3, bf3};

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_CS   = 8'b1000_0000;
    localparam logic [7:0] O_LU   = 8'b0111_0000;
    localparam logic [7:0] O_RD   = 8'b0000_1110;
    localparam logic [7:0] O_FL   = 8'b0000_1100;
    localparam logic [7:0] O_BUSY = 8'b0000_0001;

    typedef struct {
        string       tag;
        logic [7:0]  e1;
        logic [31:0] p1;
        logic [7:0]  e3;
        logic [31:0] p3;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            chk({e.tag, "/f1.ctl"}, {24'd0, v1}, {24'd0, e.e1});
            chk({e.tag, "/f1.pc"},  rpc1, e.p1);
            chk({e.tag, "/f3.ctl"}, {24'd0, v3}, {24'd0, e.e3});
            chk({e.tag, "/f3.pc"},  rpc3, e.p3);
        end
    end

    task automatic exp(input string tag, input logic [7:0] e1, input logic [31:0] p1,
                       input logic [7:0] e3, input logic [31:0] p3);
        sb_t e;
        e.tag = tag; e.e1 = e1; e.p1 = p1; e.e3 = e3; e.p3 = p3;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge and return all inputs to idle.
    task automatic nxt();
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_valid = 0; id_rs2_valid = 0;
        ex_rd_addr = '0; ex_rd_valid = 0; ex_is_load = 0;
        branch_taken = 0; branch_target = '0; icache_stall = 0; dcache_stall = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1v,
                          input logic [4:0] rs2, input logic rs2v);
        ex_is_load = 1; ex_rd_valid = 1; ex_rd_addr = rd;
        id_rs1_addr = rs1; id_rs1_valid = rs1v; id_rs2_addr = rs2; id_rs2_valid = rs2v;
    endtask

    initial begin
        nxt(); rst = 1; icache_stall = 1;
        exp("reset", O_CS, 32'h0, O_CS, 32'h0);
        nxt(); exp("idle", O_NONE, 32'h0, O_NONE, 32'h0);

        nxt(); set_lu(5'd5, 5'd5, 1, 5'd0, 0);
        exp("lu_rs1", O_LU, 32'h0, O_LU, 32'h0);
        nxt(); exp("lu_clear", O_NONE, 32'h0, O_NONE, 32'h0);
        nxt(); set_lu(5'd0, 5'd0, 1, 5'd0, 1);
        exp("lu_x0", O_NONE, 32'h0, O_NONE, 32'h0);
        nxt(); set_lu(5'd7, 5'd1, 1, 5'd7, 1);
        exp("lu_rs2", O_LU, 32'h0, O_LU, 32'h0);
        nxt(); set_lu(5'd7, 5'd1, 1, 5'd7, 0);
        exp("lu_rs2_invalid", O_NONE, 32'h0, O_NONE, 32'h0);

        nxt(); branch_taken = 1; branch_target = 32'h0000_0100;
        exp("br", O_RD, 32'h100, O_RD, 32'h100);
        nxt(); exp("br+1", O_NONE, 32'h100, O_FL | O_BUSY, 32'h100);
        nxt(); exp("br+2", O_NONE, 32'h100, O_FL | O_BUSY, 32'h100);
        nxt(); exp("br+3", O_NONE, 32'h100, O_NONE, 32'h100);

        nxt(); dcache_stall = 1; branch_taken = 1; branch_target = 32'h0000_2000;
        exp("br_stall", O_CS, 32'h100, O_CS, 32'h100);
        for (int i = 0; i < 3; i++) begin
            nxt(); dcache_stall = 1;
            exp("pend", O_CS | O_BUSY, 32'h2000, O_CS | O_BUSY, 32'h2000);
        end
        nxt(); exp("pend_rel", O_RD | O_BUSY, 32'h2000, O_RD | O_BUSY, 32'h2000);
        nxt(); icache_stall = 1;
        exp("fl_stall1", O_CS, 32'h2000, O_CS | O_BUSY, 32'h2000);
        nxt(); icache_stall = 1;
        exp("fl_stall2", O_CS, 32'h2000, O_CS | O_BUSY, 32'h2000);
        // Branch + load-use together: dut1 redirects, dut3 is still flushing and ignores both.
        nxt(); branch_taken = 1; branch_target = 32'h0000_3000; set_lu(5'd5, 5'd5, 1, 5'd0, 0);
        exp("br_lu", O_RD, 32'h3000, O_FL | O_BUSY, 32'h2000);
        nxt(); set_lu(5'd5, 5'd5, 1, 5'd0, 0);
        exp("fl_last", O_LU, 32'h3000, O_FL | O_BUSY, 32'h2000);
        nxt(); exp("run", O_NONE, 32'h3000, O_NONE, 32'h2000);

        nxt(); icache_stall = 1; branch_taken = 1; branch_target = 32'h0000_4000;
        exp("br_stall2", O_CS, 32'h3000, O_CS, 32'h2000);
`ifdef PIPE_HAZARD_PERF_EN
        @(negedge clk); #1;
        chk("perf_cs1", pcs1, 32'd6); chk("perf_lu1", plu1, 32'd3); chk("perf_rd1", prd1, 32'd3);
        chk("perf_cs3", pcs3, 32'd6); chk("perf_lu3", plu3, 32'd2); chk("perf_rd3", prd3, 32'd2);
`endif
        nxt(); icache_stall = 1; rst = 1;
        exp("rst_pend", O_CS, 32'h0, O_CS, 32'h0);
        nxt(); exp("post_rst", O_NONE, 32'h0, O_NONE, 32'h0);
        nxt(); exp("no_redirect", O_NONE, 32'h0, O_NONE, 32'h0);
`ifdef PIPE_HAZARD_PERF_EN
        @(negedge clk); #1;
        chk("perf_rst", pcs1 | plu1 | prd1, 32'd0);
`endif
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (sb.size() > 0) chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
